ram_stream_reader: RTL



---
 rtl/ram_stream_reader_pkg.sv | 8 +
 rtl/ram_stream_reader_fifo.sv | 41 ++++
 rtl/ram_stream_reader.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared FSM states and FIFO sizing for ram_stream_reader.
package ram_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE_E, READ_E, DRAIN_E} ram_stream_reader_state_t;
  localparam int FIFO_DEPTH_C = 4;
  localparam int FIFO_PTR_W_C = $clog2(FIFO_DEPTH_C);
  localparam int FIFO_CNT_W_C = $clog2(FIFO_DEPTH_C + 1);
  typedef logic [FIFO_CNT_W_C-1:0] fifo_count_t;
endpackage

// File: rtl/ram_stream_reader_fifo.sv
// ram_stream_reader_fifo: 4-entry first-word-fall-through FIFO with occupancy and synchronous flush.
module ram_stream_reader_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter type entry_t = logic
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_push,
  input  entry_t      i_din,
  input  logic        i_pop,
  output entry_t      o_dout,
  output logic        o_empty,
  output fifo_count_t o_count
);
  entry_t                  r_mem [FIFO_DEPTH_C];
  logic [FIFO_PTR_W_C-1:0] r_wr, r_rd;
  fifo_count_t             r_cnt;
  logic                    w_pop;
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= i_push ? r_wr + 1'b1 : r_wr;
      r_rd  <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt <= r_cnt + fifo_count_t'(i_push) - fifo_count_t'(w_pop);
    end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: issues sequential RAM reads for a command and streams the words out with backpressure.
// Defining RAM_STREAM_READER_ABORT_EN adds an abort input that cancels the running command.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int BYTE_WIDTH_P = 4,
  parameter int ADDR_WIDTH_P = 8,
  parameter int LEN_WIDTH_P  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef RAM_STREAM_READER_ABORT_EN
  input  logic                      abort,
`endif
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_WIDTH_P-1:0]   cmd_address,
  input  logic [LEN_WIDTH_P-1:0]    cmd_length,
  output logic                      busy,
  output logic                      ram_enable,
  output logic                      ram_write_enable,
  output logic [BYTE_WIDTH_P-1:0]   ram_write_mask,
  output logic [BYTE_WIDTH_P*8-1:0] ram_data_ingress,
  output logic [ADDR_WIDTH_P-1:0]   ram_address,
  input  logic [BYTE_WIDTH_P*8-1:0] ram_data_egress,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [BYTE_WIDTH_P*8-1:0] m_tdata,
  output logic                      m_tlast
);
  localparam int DW = BYTE_WIDTH_P * 8;
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } fifo_entry_t;
  ram_stream_reader_state_t r_state, w_next;
  logic [ADDR_WIDTH_P-1:0] r_addr;
  logic [LEN_WIDTH_P-1:0]  r_rem;
  logic                    r_vld, r_last, r_cmd_ready;
  logic                    w_accept, w_issue, w_pop, w_abort, w_empty;
  fifo_count_t             w_occ;
  fifo_entry_t             w_din, w_dout;
`ifdef RAM_STREAM_READER_ABORT_EN
  assign w_abort = abort && r_state != IDLE_E;
`else
  assign w_abort = 1'b0;
`endif
  assign w_accept = r_state == IDLE_E && cmd_valid && r_cmd_ready;
  assign w_pop    = m_tvalid && m_tready;
  // Credit: every word read but not yet handed off must still fit in the FIFO.
  assign w_issue  = r_state == READ_E && !w_abort &&
                    (int'(w_occ) + int'(r_vld) - int'(w_pop)) < FIFO_DEPTH_C;
  assign w_din    = '{last: r_last, data: ram_data_egress};
  always_comb begin
    w_next = r_state;
    if (w_abort) w_next = IDLE_E;
    else if (w_accept) w_next = READ_E;
    else if (r_state == READ_E && w_issue && r_rem == '0) w_next = DRAIN_E;
    else if (r_state == DRAIN_E && !r_vld && w_occ == fifo_count_t'(w_pop)) w_next = IDLE_E;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE_E;
      r_cmd_ready <= 1'b0;
      r_addr      <= '0;
      r_rem       <= '0;
      r_vld       <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ready <= w_next == IDLE_E;
      r_vld       <= w_issue;
      r_last      <= w_issue && r_rem == '0;
      r_addr      <= w_accept ? cmd_address : w_issue ? r_addr + 1'b1 : r_addr;
      r_rem       <= w_accept ? cmd_length : w_issue ? r_rem - 1'b1 : r_rem;
    end
  ram_stream_reader_fifo #(.entry_t(fifo_entry_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_abort),
    .i_push  (r_vld && !w_abort),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_dout),
    .o_empty (w_empty),
    .o_count (w_occ)
  );
  assign cmd_ready        = r_cmd_ready;
  assign busy             = r_state != IDLE_E;
  assign ram_enable       = w_issue;
  assign ram_address      = w_issue ? r_addr : '0;
  assign ram_write_enable = 1'b0;
  assign ram_write_mask   = '0;
  assign ram_data_ingress = '0;
  assign m_tvalid         = !w_empty;
  assign m_tdata          = m_tvalid ? w_dout.data : '0;
  assign m_tlast          = m_tvalid && w_dout.last;
endmodule
